// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch, data and memory-macro signals of the unified memory arbiter
interface mem_bus_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AWIDTH = 14
);
  logic              inst_req;
  logic [AWIDTH-1:0] inst_addr;
  logic              inst_ack;
  logic              inst_rvalid;
  logic [XLEN-1:0]   inst_rdata;
  logic              data_req;
  logic [AWIDTH-1:0] data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic [2:0]        data_we;
  logic              data_ack;
  logic              data_rvalid;
  logic [XLEN-1:0]   data_rdata;
  logic              mem_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [2:0]        mem_we;
  logic [XLEN-1:0]   mem_rdata;
  logic              busy;
  modport slave (
    input  inst_req, inst_addr, data_req, data_addr, data_wdata, data_we, mem_rdata,
    output inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
           mem_en, mem_addr, mem_wdata, mem_we, busy
  );
  modport master (
    output inst_req, inst_addr, data_req, data_addr, data_wdata, data_we, mem_rdata,
    input  inst_ack, inst_rvalid, inst_rdata, data_ack, data_rvalid, data_rdata,
           mem_en, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between fetch and data, data first with a fetch starvation guard
module mem_bus_arbiter #(
  parameter int XLEN = 32,
  parameter int AWIDTH = 14,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst_n,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [2:0] RL = 3'(RD_LATENCY);
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  state_t     state, state_nx;
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       owner, inst_win, data_win, rd_grant, rd_done;
  // rst_n gates the grant so every output reads 0 while reset is held
  always_comb begin
    inst_win = rst_n && state == IDLE && bus.inst_req && (!bus.data_req || starve_cnt == SL);
    data_win = rst_n && state == IDLE && bus.data_req && !inst_win;
    rd_grant = inst_win || (data_win && bus.data_we == 3'b000);
    rd_done  = state == WAIT && lat_cnt == RL;
    state_nx = rd_grant ? WAIT : rd_done ? IDLE : state;
  end
  always_comb begin
    bus.inst_ack    = inst_win;
    bus.data_ack    = data_win;
    bus.mem_en      = inst_win || data_win;
    bus.mem_addr    = inst_win ? bus.inst_addr : data_win ? bus.data_addr : '0;
    bus.mem_we      = data_win ? bus.data_we : 3'b000;
    bus.mem_wdata   = (inst_win || data_win) ? bus.data_wdata : '0;
    bus.inst_rvalid = rd_done && !owner;
    bus.data_rvalid = rd_done && owner;
    bus.inst_rdata  = (rd_done && !owner) ? bus.mem_rdata : '0;
    bus.data_rdata  = (rd_done && owner) ? bus.mem_rdata : '0;
    bus.busy        = state == WAIT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      owner      <= 1'b0;
    end else begin
      state      <= state_nx;
      lat_cnt    <= rd_grant ? 3'd1 : (state == WAIT && !rd_done) ? lat_cnt + 3'd1 : 3'd0;
      owner      <= rd_grant ? data_win : owner;
      starve_cnt <= (inst_win || (state == IDLE && !bus.inst_req)) ? 4'd0 :
                    (data_win && bus.inst_req && starve_cnt != SL) ? starve_cnt + 4'd1 : starve_cnt;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter with a transaction-level reference model
module tb_mem_bus_arbiter;
  localparam int RL = 3;
  localparam int SL = 2;
  typedef struct { int cyc; logic d; logic [13:0] addr; logic [2:0] we; logic [31:0] wd; } gnt_t;
  typedef struct { int cyc; logic d; logic [31:0] data; } rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_next = 1'b0;
  logic exp_busy = 1'b0;
  int cyc = 0, wait_left = 0, losses = 0, vectors = 0, miscompares = 0;
  gnt_t gq[$];
  rd_t rq[$];
  logic [31:0] mdl[int];
  logic [31:0] mac[int];
  logic [31:0] sched[int];
  always #5 clk = ~clk;
  mem_bus_arbiter_if #(.XLEN(32), .AWIDTH(14)) bus ();
  mem_bus_arbiter #(.XLEN(32), .AWIDTH(14), .RD_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  function automatic logic [31:0] init_val(input logic [13:0] a);
    return {a, 18'h2B5A5} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] mdl_rd(input logic [13:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : init_val(a);
  endfunction
  function automatic logic [31:0] mac_rd(input logic [13:0] a);
    return mac.exists(int'(a)) ? mac[int'(a)] : init_val(a);
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, a, e);
    end
  endtask
  // Apply one cycle of stimulus and predict the arbiter's response from the access rules
  task automatic step(input logic ir, input logic [13:0] ia, input logic dr, input logic [13:0] da,
                      input logic [2:0] dw, input logic [31:0] dd, output int won);
    logic [13:0] a;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rst_next;
    bus.inst_req = ir;
    bus.inst_addr = ia;
    bus.data_req = dr;
    bus.data_addr = da;
    bus.data_we = dw;
    bus.data_wdata = dd;
    bus.mem_rdata = sched.exists(cyc) ? sched[cyc] : $urandom();
    won = 0;
    if (!rst_next) begin
      wait_left = 0;
      losses = 0;
      exp_busy = 1'b0;
      rq.delete();
    end else if (wait_left > 0) begin
      wait_left--;
      exp_busy = 1'b1;
    end else begin
      exp_busy = 1'b0;
      won = (ir && (!dr || losses == SL)) ? 1 : dr ? 2 : 0;
      losses = (won == 1 || !ir) ? 0 : (won == 2 && losses < SL) ? losses + 1 : losses;
      a = (won == 1) ? ia : da;
      if (won != 0) gq.push_back('{cyc, won == 2, a, (won == 2) ? dw : 3'b000, dd});
      if (won == 1 || (won == 2 && dw == 3'b000)) begin
        rq.push_back('{cyc + RL, won == 2, mdl_rd(a)});
        wait_left = RL;
      end else if (won == 2) mdl[int'(a)] = dd;
    end
  endtask
  // Memory macro: latches reads at the accept edge and returns data RL cycles later
  always @(negedge clk) begin
    if (rst_n && bus.mem_en) begin
      if (bus.mem_we == 3'b000) sched[cyc + RL] = mac_rd(bus.mem_addr);
      else mac[int'(bus.mem_addr)] = bus.mem_wdata;
    end
  end
  always @(negedge clk) begin
    gnt_t g;
    rd_t r;
    if (!rst_n) begin
      chk("reset_outputs", {bus.inst_ack, bus.inst_rvalid, bus.inst_rdata, bus.data_ack, bus.data_rvalid,
          bus.data_rdata, bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.busy}, '0);
    end else begin
      chk("busy", bus.busy, exp_busy);
      if (bus.mem_en || bus.inst_ack || bus.data_ack) begin
        chk("grant_pending", gq.size() > 0, 1'b1);
        if (gq.size() > 0) begin
          g = gq.pop_front();
          chk("grant", {cyc, bus.inst_ack, bus.data_ack, bus.mem_en, bus.mem_addr, bus.mem_we, bus.mem_wdata},
              {g.cyc, !g.d, g.d, 1'b1, g.addr, g.we, g.wd});
        end
      end else begin
        chk("idle_bus", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, '0);
        if (gq.size() > 0 && gq[0].cyc <= cyc) begin
          void'(gq.pop_front());
          chk("grant_present", bus.mem_en, 1'b1);
        end
      end
      if (bus.inst_rvalid || bus.data_rvalid) begin
        chk("rvalid_pending", rq.size() > 0, 1'b1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          chk("rdata", {cyc, bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata, bus.data_rdata},
              {r.cyc, !r.d, r.d, r.d ? 32'h0 : r.data, r.d ? r.data : 32'h0});
        end
      end else begin
        chk("rdata_idle", {bus.inst_rdata, bus.data_rdata}, '0);
        if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          void'(rq.pop_front());
          chk("rvalid_present", bus.inst_rvalid | bus.data_rvalid, 1'b1);
        end
      end
    end
  end
  task automatic idle(input int n);
    int won;
    repeat (n) step(1'b0, '0, 1'b0, '0, 3'b000, '0, won);
  endtask
  task automatic rand_phase(input int n);
    logic ip, dp;
    logic [13:0] ia, da;
    logic [2:0] dw;
    logic [31:0] dd;
    int won;
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dw = '0; dd = '0;
    repeat (n) begin
      if (!ip && $urandom_range(0, 99) < 40) begin
        ip = 1'b1;
        ia = 14'($urandom_range(0, 63));
      end else if (ip && $urandom_range(0, 99) < 3) ip = 1'b0;
      if (!dp && $urandom_range(0, 99) < 45) begin
        dp = 1'b1;
        da = 14'($urandom_range(0, 63));
        dw = ($urandom_range(0, 99) < 50) ? 3'b000 : 3'($urandom_range(1, 7));
        dd = $urandom();
      end else if (dp && $urandom_range(0, 99) < 3) dp = 1'b0;
      step(ip, ia, dp, da, dw, dd, won);
      if (won == 1) ip = 1'b0;
      if (won == 2) dp = 1'b0;
    end
  endtask
  initial begin
    int won;
    bus.inst_req = 1'b0; bus.inst_addr = '0; bus.data_req = 1'b0; bus.data_addr = '0;
    bus.data_we = '0; bus.data_wdata = '0; bus.mem_rdata = '0;
    mdl[16] = 32'h13;
    mac[16] = 32'h13;
    repeat (3) step(1'b1, 14'h010, 1'b1, 14'h020, 3'b111, 32'hFFFF_FFFF, won);
    rst_next = 1'b1;
    step(1'b1, 14'h010, 1'b0, '0, 3'b000, '0, won);
    idle(RL + 1);
    step(1'b1, 14'h010, 1'b1, 14'h020, 3'b000, '0, won);
    repeat (RL + 1) step(1'b1, 14'h010, 1'b0, '0, 3'b000, '0, won);
    idle(RL + 1);
    step(1'b1, 14'h011, 1'b1, 14'h030, 3'b111, 32'hDEAD_BEEF, won);
    step(1'b1, 14'h011, 1'b0, '0, 3'b000, '0, won);
    idle(RL + 1);
    for (int k = 0; k < 3; k++) step(1'b1, 14'h040, 1'b1, 14'(32'h50 + k), 3'b111, 32'(k), won);
    idle(RL + 1);
    step(1'b0, '0, 1'b1, 14'h030, 3'b000, '0, won);
    idle(RL + 1);
    rand_phase(2000);
    idle(RL + 2);
    step(1'b0, '0, 1'b1, 14'h060, 3'b000, '0, won);
    idle(1);
    rst_next = 1'b0;
    repeat (2) step(1'b1, 14'h061, 1'b1, 14'h062, 3'b111, 32'hCAFE_F00D, won);
    rst_next = 1'b1;
    step(1'b0, '0, 1'b1, 14'h063, 3'b001, 32'h0000_1234, won);
    idle(RL + 3);
    rand_phase(300);
    idle(RL + 3);
    @(negedge clk);
    #1;
    chk("grants_drained", gq.size(), 0);
    chk("reads_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
